// File: rtl/hack_kbd_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | hack_kbd_pkg: shared key codes, scan codes and types for the KBD path |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package hack_kbd_pkg;

  localparam logic [7:0] KEY_NEWLINE   = 8'd128;
  localparam logic [7:0] KEY_BACKSPACE = 8'd129;
  localparam logic [7:0] KEY_LEFT      = 8'd130;
  localparam logic [7:0] KEY_UP        = 8'd131;
  localparam logic [7:0] KEY_RIGHT     = 8'd132;
  localparam logic [7:0] KEY_DOWN      = 8'd133;
  localparam logic [7:0] KEY_HOME      = 8'd134;
  localparam logic [7:0] KEY_END       = 8'd135;
  localparam logic [7:0] KEY_PGUP      = 8'd136;
  localparam logic [7:0] KEY_PGDN      = 8'd137;
  localparam logic [7:0] KEY_INSERT    = 8'd138;
  localparam logic [7:0] KEY_DELETE    = 8'd139;
  localparam logic [7:0] KEY_ESC       = 8'd140;
  localparam logic [7:0] KEY_F1        = 8'd141;
  localparam logic [7:0] KEY_F12       = 8'd152;

  localparam logic [7:0] SC_SHIFT_L = 8'h12;
  localparam logic [7:0] SC_SHIFT_R = 8'h59;
  localparam logic [7:0] SC_CAPS    = 8'h58;

  typedef struct packed {
    logic       ext;
    logic [7:0] scan;
  } held_code_t;

  function automatic logic [7:0] pick(input logic sel, input logic [7:0] lo, input logic [7:0] hi);
    return sel ? hi : lo;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hack_scancode_lut.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | hack_scancode_lut: PS/2 set-2 scan code to Hack key code, 0=unmapped  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module hack_scancode_lut
  import hack_kbd_pkg::*;
(
  input  logic       i_ext,
  input  logic [7:0] i_scan,
  input  logic       i_shift,
  input  logic       i_upcase,
  output logic [7:0] o_code
);

  always_comb begin
    o_code = 8'd0;
    if (i_ext) begin
      case (i_scan)
        8'h6B:   o_code = KEY_LEFT;
        8'h75:   o_code = KEY_UP;
        8'h74:   o_code = KEY_RIGHT;
        8'h72:   o_code = KEY_DOWN;
        8'h6C:   o_code = KEY_HOME;
        8'h69:   o_code = KEY_END;
        8'h7D:   o_code = KEY_PGUP;
        8'h7A:   o_code = KEY_PGDN;
        8'h70:   o_code = KEY_INSERT;
        8'h71:   o_code = KEY_DELETE;
        default: o_code = 8'd0;
      endcase
    end else begin
      case (i_scan)
        // letters follow shift xor caps; everything else follows shift alone
        8'h1C: o_code = pick(i_upcase, 8'h61, 8'h41);
        8'h32: o_code = pick(i_upcase, 8'h62, 8'h42);
        8'h21: o_code = pick(i_upcase, 8'h63, 8'h43);
        8'h23: o_code = pick(i_upcase, 8'h64, 8'h44);
        8'h24: o_code = pick(i_upcase, 8'h65, 8'h45);
        8'h2B: o_code = pick(i_upcase, 8'h66, 8'h46);
        8'h34: o_code = pick(i_upcase, 8'h67, 8'h47);
        8'h33: o_code = pick(i_upcase, 8'h68, 8'h48);
        8'h43: o_code = pick(i_upcase, 8'h69, 8'h49);
        8'h3B: o_code = pick(i_upcase, 8'h6A, 8'h4A);
        8'h42: o_code = pick(i_upcase, 8'h6B, 8'h4B);
        8'h4B: o_code = pick(i_upcase, 8'h6C, 8'h4C);
        8'h3A: o_code = pick(i_upcase, 8'h6D, 8'h4D);
        8'h31: o_code = pick(i_upcase, 8'h6E, 8'h4E);
        8'h44: o_code = pick(i_upcase, 8'h6F, 8'h4F);
        8'h4D: o_code = pick(i_upcase, 8'h70, 8'h50);
        8'h15: o_code = pick(i_upcase, 8'h71, 8'h51);
        8'h2D: o_code = pick(i_upcase, 8'h72, 8'h52);
        8'h1B: o_code = pick(i_upcase, 8'h73, 8'h53);
        8'h2C: o_code = pick(i_upcase, 8'h74, 8'h54);
        8'h3C: o_code = pick(i_upcase, 8'h75, 8'h55);
        8'h2A: o_code = pick(i_upcase, 8'h76, 8'h56);
        8'h1D: o_code = pick(i_upcase, 8'h77, 8'h57);
        8'h22: o_code = pick(i_upcase, 8'h78, 8'h58);
        8'h35: o_code = pick(i_upcase, 8'h79, 8'h59);
        8'h1A: o_code = pick(i_upcase, 8'h7A, 8'h5A);
        8'h16: o_code = pick(i_shift, 8'h31, 8'h21);
        8'h1E: o_code = pick(i_shift, 8'h32, 8'h40);
        8'h26: o_code = pick(i_shift, 8'h33, 8'h23);
        8'h25: o_code = pick(i_shift, 8'h34, 8'h24);
        8'h2E: o_code = pick(i_shift, 8'h35, 8'h25);
        8'h36: o_code = pick(i_shift, 8'h36, 8'h5E);
        8'h3D: o_code = pick(i_shift, 8'h37, 8'h26);
        8'h3E: o_code = pick(i_shift, 8'h38, 8'h2A);
        8'h46: o_code = pick(i_shift, 8'h39, 8'h28);
        8'h45: o_code = pick(i_shift, 8'h30, 8'h29);
        8'h0E: o_code = pick(i_shift, 8'h60, 8'h7E);
        8'h4E: o_code = pick(i_shift, 8'h2D, 8'h5F);
        8'h55: o_code = pick(i_shift, 8'h3D, 8'h2B);
        8'h54: o_code = pick(i_shift, 8'h5B, 8'h7B);
        8'h5B: o_code = pick(i_shift, 8'h5D, 8'h7D);
        8'h5D: o_code = pick(i_shift, 8'h5C, 8'h7C);
        8'h4C: o_code = pick(i_shift, 8'h3B, 8'h3A);
        8'h52: o_code = pick(i_shift, 8'h27, 8'h22);
        8'h41: o_code = pick(i_shift, 8'h2C, 8'h3C);
        8'h49: o_code = pick(i_shift, 8'h2E, 8'h3E);
        8'h4A: o_code = pick(i_shift, 8'h2F, 8'h3F);
        8'h29: o_code = 8'h20;
        8'h5A: o_code = KEY_NEWLINE;
        8'h66: o_code = KEY_BACKSPACE;
        8'h76: o_code = KEY_ESC;
        8'h05: o_code = KEY_F1;
        8'h06: o_code = KEY_F1 + 8'd1;
        8'h04: o_code = KEY_F1 + 8'd2;
        8'h0C: o_code = KEY_F1 + 8'd3;
        8'h03: o_code = KEY_F1 + 8'd4;
        8'h0B: o_code = KEY_F1 + 8'd5;
        8'h83: o_code = KEY_F1 + 8'd6;
        8'h0A: o_code = KEY_F1 + 8'd7;
        8'h01: o_code = KEY_F1 + 8'd8;
        8'h09: o_code = KEY_F1 + 8'd9;
        8'h78: o_code = KEY_F1 + 8'd10;
        8'h07: o_code = KEY_F12;
        default: o_code = 8'd0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/hack_keyboard_encoder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | hack_keyboard_encoder: PS/2 key bus to Hack KBD register value        |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module hack_keyboard_encoder
  import hack_kbd_pkg::*;
(
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  output logic [15:0] kbd,
  output logic        kbd_changed
);

  logic [10:0] r_key;
  logic        r_tog_prev;
  logic        r_primed;
  logic        r_shift_l;
  logic        r_shift_r;
  logic        r_caps;
  held_code_t  r_held;
  logic [7:0]  r_kbd;
  logic        r_changed;

  logic        w_event;
  logic        w_press;
  held_code_t  w_key_id;
  logic        w_shift;
  logic        w_upcase;
  logic [7:0]  w_code;

  assign w_event  = r_key[10] ^ r_tog_prev;
  assign w_press  = r_key[9];
  assign w_key_id = r_key[8:0];
  assign w_shift  = r_shift_l | r_shift_r;
  assign w_upcase = w_shift ^ r_caps;

  hack_scancode_lut u_lut (
    .i_ext    (w_key_id.ext),
    .i_scan   (w_key_id.scan),
    .i_shift  (w_shift),
    .i_upcase (w_upcase),
    .o_code   (w_code)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_key      <= 11'd0;
      r_tog_prev <= 1'b0;
      r_primed   <= 1'b0;
      r_shift_l  <= 1'b0;
      r_shift_r  <= 1'b0;
      r_caps     <= 1'b0;
      r_held     <= '0;
      r_kbd      <= 8'd0;
      r_changed  <= 1'b0;
    end else begin
      r_key      <= ps2_key;
      // first edge after reset seeds the toggle history so no phantom event appears
      r_tog_prev <= r_primed ? r_key[10] : ps2_key[10];
      r_primed   <= 1'b1;
      r_changed  <= 1'b0;
      if (w_event) begin
        if (!w_key_id.ext && w_key_id.scan == SC_SHIFT_L) begin
          r_shift_l <= w_press;
        end else if (!w_key_id.ext && w_key_id.scan == SC_SHIFT_R) begin
          r_shift_r <= w_press;
        end else if (!w_key_id.ext && w_key_id.scan == SC_CAPS) begin
          if (w_press) r_caps <= ~r_caps;
        end else if (w_press) begin
          if (w_code != 8'd0) begin
            r_kbd     <= w_code;
            r_held    <= w_key_id;
            r_changed <= (w_code != r_kbd);
          end
        end else if (w_key_id == r_held) begin
          r_kbd     <= 8'd0;
          r_held    <= '0;
          r_changed <= (r_kbd != 8'd0);
        end
      end
    end
  end

  assign kbd         = {8'h00, r_kbd};
  assign kbd_changed = r_changed;

endmodule
`default_nettype wire

// File: tb/tb_hack_keyboard_encoder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_hack_keyboard_encoder: directed plus random checks against a model |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_hack_keyboard_encoder;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic [15:0] kbd;
    logic        kbd_changed;

    hack_keyboard_encoder dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ps2_key     (ps2_key),
        .kbd         (kbd),
        .kbd_changed (kbd_changed)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference tables: scan codes listed in glyph order
    logic [7:0] let_sc [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,8'h42,8'h4B,8'h3A,
                                8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
    logic [7:0] dig_sc [10] = '{8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46,8'h45};
    logic [7:0] pun_sc [11] = '{8'h0E,8'h4E,8'h55,8'h54,8'h5B,8'h5D,8'h4C,8'h52,8'h41,8'h49,8'h4A};
    logic [7:0] fn_sc  [12] = '{8'h05,8'h06,8'h04,8'h0C,8'h03,8'h0B,8'h83,8'h0A,8'h01,8'h09,8'h78,8'h07};
    logic [7:0] ext_sc [10] = '{8'h6B,8'h75,8'h74,8'h72,8'h6C,8'h69,8'h7D,8'h7A,8'h70,8'h71};
    string dig_lo = "1234567890";
    string dig_hi = "!@#$%^&*()";
    logic [7:0] pun_lo [11] = '{8'h60,8'h2D,8'h3D,8'h5B,8'h5D,8'h5C,8'h3B,8'h27,8'h2C,8'h2E,8'h2F};
    logic [7:0] pun_hi [11] = '{8'h7E,8'h5F,8'h2B,8'h7B,8'h7D,8'h7C,8'h3A,8'h22,8'h3C,8'h3E,8'h3F};

    logic [7:0] pool [28] = '{8'h1C,8'h32,8'h1A,8'h4D,8'h16,8'h45,8'h4E,8'h4A,8'h0E,8'h29,8'h5A,8'h66,8'h76,8'h05,
                              8'h83,8'h07,8'h12,8'h59,8'h58,8'h6B,8'h75,8'h71,8'h70,8'h00,8'h1F,8'h5D,8'h52,8'h36};

    function automatic int ref_map(input bit ex, input logic [7:0] sc, input bit sh, input bit cp);
        if (ex) begin
            foreach (ext_sc[i]) if (ext_sc[i] == sc) return 130 + i;
            return 0;
        end
        foreach (let_sc[i]) if (let_sc[i] == sc) return ((sh ^ cp) ? 65 : 97) + i;
        foreach (dig_sc[i]) if (dig_sc[i] == sc) return sh ? int'(dig_hi[i]) : int'(dig_lo[i]);
        foreach (pun_sc[i]) if (pun_sc[i] == sc) return sh ? int'(pun_hi[i]) : int'(pun_lo[i]);
        foreach (fn_sc[i])  if (fn_sc[i]  == sc) return 141 + i;
        if (sc == 8'h29) return 32;
        if (sc == 8'h5A) return 128;
        if (sc == 8'h66) return 129;
        if (sc == 8'h76) return 140;
        return 0;
    endfunction

    // Model state: modifiers, held key identity (-1 = none), visible code
    bit m_shl, m_shr, m_caps;
    int m_held, m_kbd;
    bit exp_chg;
    bit p_ev, p_pr, p_ex;
    logic [7:0] p_sc;
    bit tog;

    function automatic void model_clear();
        m_shl = 0; m_shr = 0; m_caps = 0; m_held = -1; m_kbd = 0; p_ev = 0; exp_chg = 0;
    endfunction

    function automatic void model_apply(input bit pr, input bit ex, input logic [7:0] sc);
        int c, old, id;
        old = m_kbd;
        id  = {23'd0, ex, sc};
        if (!ex && sc == 8'h12)      m_shl = pr;
        else if (!ex && sc == 8'h59) m_shr = pr;
        else if (!ex && sc == 8'h58) begin if (pr) m_caps = !m_caps; end
        else if (pr) begin
            c = ref_map(ex, sc, m_shl | m_shr, m_caps);
            if (c != 0) begin m_kbd = c; m_held = id; end
        end else if (id == m_held) begin
            m_kbd = 0; m_held = -1;
        end
        exp_chg = (m_kbd != old);
    endfunction

    // One clock: optionally present a new event, then compare after the edge
    task automatic step(input bit ev, input bit pr, input bit ex, input logic [7:0] sc);
        if (ev) begin
            tog = !tog;
            ps2_key = {tog, pr, ex, sc};
        end
        @(posedge clk_sys);
        exp_chg = 0;
        if (p_ev) model_apply(p_pr, p_ex, p_sc);
        p_ev = ev; p_pr = pr; p_ex = ex; p_sc = sc;
        @(negedge clk_sys);
        check("kbd", kbd, m_kbd[15:0]);
        check("kbd_changed", {15'd0, kbd_changed}, {15'd0, exp_chg});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00);
    endtask

    task automatic make(input bit ex, input logic [7:0] sc);
        step(1, 1, ex, sc);
    endtask

    task automatic brk(input bit ex, input logic [7:0] sc);
        step(1, 0, ex, sc);
    endtask

    initial begin
        reset_n = 1'b0;
        tog     = 1'b1;
        ps2_key = {1'b1, 10'd0};
        model_clear();
        repeat (3) @(negedge clk_sys);
        check("reset_kbd", kbd, 16'd0);
        check("reset_chg", {15'd0, kbd_changed}, 16'd0);
        reset_n = 1'b1;
        idle(4);

        // plain letter make/break
        make(0, 8'h1C); idle(1);
        check("plan_a", kbd, 16'd97);
        brk(0, 8'h1C); idle(1);
        check("plan_a_rel", kbd, 16'd0);

        // shifted digit survives shift release
        make(0, 8'h12); make(0, 8'h16); idle(1);
        check("plan_bang", kbd, 16'd33);
        brk(0, 8'h12); idle(1);
        check("plan_bang_hold", kbd, 16'd33);
        brk(0, 8'h16); idle(1);
        check("plan_bang_rel", kbd, 16'd0);

        // caps with and without shift
        make(0, 8'h58); brk(0, 8'h58); make(0, 8'h12); make(0, 8'h1C); idle(1);
        check("plan_caps_shift", kbd, 16'd97);
        brk(0, 8'h1C); brk(0, 8'h12); make(0, 8'h1C); idle(1);
        check("plan_caps", kbd, 16'd65);
        brk(0, 8'h1C); make(0, 8'h58); brk(0, 8'h58); idle(1);

        // extended flag is part of key identity
        make(1, 8'h6B); idle(1);
        check("plan_left", kbd, 16'd130);
        brk(0, 8'h6B); idle(1);
        check("plan_left_hold", kbd, 16'd130);
        brk(1, 8'h6B); idle(1);
        check("plan_left_rel", kbd, 16'd0);

        // auto-repeat: no second pulse
        make(0, 8'h29); make(0, 8'h29); make(0, 8'h29); idle(1);
        check("plan_space", kbd, 16'd32);
        brk(0, 8'h29); idle(1);

        // four events on consecutive cycles
        make(0, 8'h12); make(0, 8'h1C); brk(0, 8'h1C); make(0, 8'h5A); idle(1);
        check("plan_b2b", kbd, 16'd128);
        brk(0, 8'h12); brk(0, 8'h5A); idle(1);

        for (int i = 0; i < 500; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 3) begin
                ps2_key[9:0] = 10'($urandom);
                idle(1);
            end else begin
                bit pr;
                pr = 1'($urandom);
                if (!pr && m_held >= 0 && $urandom_range(0, 1) == 1)
                    brk(m_held[8], m_held[7:0]);
                else
                    step(1, pr, $urandom_range(0, 4) == 0, pool[$urandom_range(0, 27)]);
            end
        end
        idle(2);

        // reset with an event in flight discards it
        make(0, 8'h32);
        reset_n = 1'b0;
        #1;
        check("midreset_kbd", kbd, 16'd0);
        check("midreset_chg", {15'd0, kbd_changed}, 16'd0);
        @(negedge clk_sys);
        model_clear();
        reset_n = 1'b1;
        idle(3);
        make(0, 8'h4E); idle(1);
        check("post_reset_minus", kbd, 16'd45);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
